// File: rtl/pr_dst_accumulate_pkg.sv
// pr_dst_accumulate_pkg
//   Shared definitions for the PageRank destination accumulator:
//   IEEE-754 single constants and field layout, FSM state encoding,
//   destination-lane count and a small popcount helper.
//   Also supplies default values for the sizing macros EDGE_PIPE_NUM,
//   VERTEX_BRAM_DWIDTH, MASK_WIDTH and DST_ID_DWIDTH when the build does
//   not define them.
`ifndef EDGE_PIPE_NUM
`define EDGE_PIPE_NUM 4
`endif
`ifndef VERTEX_BRAM_DWIDTH
`define VERTEX_BRAM_DWIDTH 32
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH `EDGE_PIPE_NUM
`endif
`ifndef DST_ID_DWIDTH
`define DST_ID_DWIDTH 16
`endif

package pr_dst_accumulate_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;

    localparam logic [FP_W-1:0] FP_ZERO  = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_QNAN  = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] FP_QUIET = 32'h0040_0000;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } fp32_t;

    localparam int DST_LANES = 4;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/pr_dst_accumulate_if.sv
// pr_dst_accumulate_if
//   Input beat bus of the destination accumulator: one src_p beat with
//   EDGE_PIPE_NUM float lanes, plus four destination lanes each carrying
//   an id, a lane-select mask and a valid.
//   master: beat producer.  slave: pr_dst_accumulate.
`ifndef EDGE_PIPE_NUM
`define EDGE_PIPE_NUM 4
`endif
`ifndef VERTEX_BRAM_DWIDTH
`define VERTEX_BRAM_DWIDTH 32
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH `EDGE_PIPE_NUM
`endif
`ifndef DST_ID_DWIDTH
`define DST_ID_DWIDTH 16
`endif

interface pr_dst_accumulate_if #(
    parameter int EDGE_PIPE_NUM      = `EDGE_PIPE_NUM,
    parameter int VERTEX_BRAM_DWIDTH = `VERTEX_BRAM_DWIDTH,
    parameter int MASK_WIDTH         = `MASK_WIDTH,
    parameter int DST_ID_DWIDTH      = `DST_ID_DWIDTH
);
    logic [VERTEX_BRAM_DWIDTH*EDGE_PIPE_NUM-1:0] src_p;
    logic                                        src_p_valid;
    logic [DST_ID_DWIDTH-1:0] dst_id_1, dst_id_2, dst_id_3, dst_id_4;
    logic [MASK_WIDTH-1:0]    src_p_mask_r_1, src_p_mask_r_2, src_p_mask_r_3, src_p_mask_r_4;
    logic                     dst_data_valid_1, dst_data_valid_2, dst_data_valid_3, dst_data_valid_4;

    modport master (
        output src_p, src_p_valid,
        output dst_id_1, dst_id_2, dst_id_3, dst_id_4,
        output src_p_mask_r_1, src_p_mask_r_2, src_p_mask_r_3, src_p_mask_r_4,
        output dst_data_valid_1, dst_data_valid_2, dst_data_valid_3, dst_data_valid_4
    );

    modport slave (
        input src_p, src_p_valid,
        input dst_id_1, dst_id_2, dst_id_3, dst_id_4,
        input src_p_mask_r_1, src_p_mask_r_2, src_p_mask_r_3, src_p_mask_r_4,
        input dst_data_valid_1, dst_data_valid_2, dst_data_valid_3, dst_data_valid_4
    );
endinterface

// File: rtl/pr_dst_accumulate_lane.sv
// pr_dst_accumulate_lane
//   One destination lane: masked float sum of the beat's src_p lanes
//   (lane 0 upward) and a single running accumulator keyed by dst id.
//   Ports: clk, rst (sync, active-high); src_p, mask, dst_id (beat data);
//   accept (beat taken this cycle); flush_start (RUN cycle with flush_req);
//   flush_now (FLUSH state); wr_en/wr_addr/wr_data (registered write).
module pr_dst_accumulate_lane
    import pr_dst_accumulate_pkg::*;
#(
    parameter int EDGE_PIPE_NUM      = 4,
    parameter int VERTEX_BRAM_DWIDTH = 32,
    parameter int MASK_WIDTH         = 4,
    parameter int DST_ID_DWIDTH      = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [VERTEX_BRAM_DWIDTH*EDGE_PIPE_NUM-1:0] src_p,
    input  logic [MASK_WIDTH-1:0]                       mask,
    input  logic [DST_ID_DWIDTH-1:0]                    dst_id,
    input  logic                                        accept,
    input  logic                                        flush_start,
    input  logic                                        flush_now,
    output logic                                        wr_en,
    output logic [DST_ID_DWIDTH-1:0]                    wr_addr,
    output logic [VERTEX_BRAM_DWIDTH-1:0]               wr_data
);
    logic [EDGE_PIPE_NUM:0][VERTEX_BRAM_DWIDTH-1:0]   chain;
    logic [EDGE_PIPE_NUM-1:0][VERTEX_BRAM_DWIDTH-1:0] chain_add;
    logic [EDGE_PIPE_NUM-1:0]                         sel;
    logic [VERTEX_BRAM_DWIDTH-1:0]                    partial, acc_sum;

    assign chain[0] = FP_ZERO;

    // Deselected lanes are bypassed rather than added as zero.
    for (genvar i = 0; i < EDGE_PIPE_NUM; i++) begin : g_sum
        if (i < MASK_WIDTH) begin : g_m
            assign sel[i] = mask[i];
        end else begin : g_nm
            assign sel[i] = 1'b0;
        end
        pr_float_add u_add (
            .a (chain[i]),
            .b (src_p[i*VERTEX_BRAM_DWIDTH +: VERTEX_BRAM_DWIDTH]),
            .y (chain_add[i])
        );
        assign chain[i+1] = sel[i] ? chain_add[i] : chain[i];
    end
    assign partial = chain[EDGE_PIPE_NUM];

    logic [VERTEX_BRAM_DWIDTH-1:0] acc_val_q, acc_val_d, nxt_val;
    logic [DST_ID_DWIDTH-1:0]      acc_id_q, acc_id_d, nxt_id;
    logic                          acc_active_q, acc_active_d, nxt_act, evict;
    logic                          wr_en_q, wr_en_d;
    logic [DST_ID_DWIDTH-1:0]      wr_addr_q, wr_addr_d;
    logic [VERTEX_BRAM_DWIDTH-1:0] wr_data_q, wr_data_d;

    pr_float_add u_acc (.a(acc_val_q), .b(partial), .y(acc_sum));

    always_comb begin
        nxt_val = acc_val_q;
        nxt_id  = acc_id_q;
        nxt_act = acc_active_q;
        evict   = 1'b0;
        if (accept) begin
            if (acc_active_q && acc_id_q == dst_id) begin
                nxt_val = acc_sum;
            end else begin
                evict   = acc_active_q;
                nxt_val = partial;
                nxt_id  = dst_id;
                nxt_act = 1'b1;
            end
        end

        acc_val_d    = nxt_val;
        acc_id_d     = nxt_id;
        acc_active_d = nxt_act;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        if (flush_now && acc_active_q) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = acc_id_q;
            wr_data_d    = acc_val_q;
            acc_active_d = 1'b0;
        end else if (evict) begin
            wr_en_d   = 1'b1;
            wr_addr_d = acc_id_q;
            wr_data_d = acc_val_q;
        end else if (flush_start && nxt_act) begin
            // Flush write issued early so it lands in the FLUSH cycle. If the
            // port is taken by an eviction, the lane stays active and the
            // FLUSH state writes it out one cycle later instead.
            wr_en_d      = 1'b1;
            wr_addr_d    = nxt_id;
            wr_data_d    = nxt_val;
            acc_active_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_val_q    <= '0;
            acc_id_q     <= '0;
            acc_active_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            acc_val_q    <= acc_val_d;
            acc_id_q     <= acc_id_d;
            acc_active_q <= acc_active_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
endmodule

// File: rtl/pr_float_add.sv
// pr_float_add
//   Combinational IEEE-754 single-precision adder.
//   Ports: a, b (operands), y (a + b).
//   Round-to-nearest-even; denormal inputs and underflowing results become
//   signed zero; NaN operands propagate quieted, Inf - Inf gives the
//   default quiet NaN, overflow gives signed Inf.
module pr_float_add
    import pr_dst_accumulate_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] y
);
    fp32_t              fa, fb, big, sml;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic               eff_sub, sticky, found, round_up;
    logic [7:0]         d_exp;
    logic [26:0]        ma, mb, mb_sh, sh_mask, norm;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic signed [9:0]  exp_n, exp_r;
    logic [24:0]        rnd;
    logic [22:0]        mant;

    always_comb begin
        fa     = a;
        fb     = b;
        a_nan  = (&fa.exp) && (|fa.man);
        b_nan  = (&fb.exp) && (|fb.man);
        a_inf  = (&fa.exp) && !(|fa.man);
        b_inf  = (&fb.exp) && !(|fb.man);
        a_zero = (fa.exp == '0);
        b_zero = (fb.exp == '0);

        // Larger magnitude goes first so the aligned difference is never negative.
        if ({fb.exp, fb.man} > {fa.exp, fa.man}) begin
            big = fb;
            sml = fa;
        end else begin
            big = fa;
            sml = fb;
        end
        d_exp = big.exp - sml.exp;

        // Layout: [26] hidden, [25:3] mantissa, [2] guard, [1] round, [0] sticky.
        ma = {1'b1, big.man, 3'b000};
        mb = {1'b1, sml.man, 3'b000};
        if (d_exp >= 8'd27) begin
            mb_sh   = '0;
            sh_mask = '1;
            sticky  = 1'b1;
        end else begin
            mb_sh   = mb >> d_exp;
            sh_mask = ~({27{1'b1}} << d_exp);
            sticky  = |(mb & sh_mask);
        end
        mb_sh[0] = mb_sh[0] | sticky;

        eff_sub = fa.sign ^ fb.sign;
        sum = eff_sub ? ({1'b0, ma} - {1'b0, mb_sh}) : ({1'b0, ma} + {1'b0, mb_sh});

        lz    = '0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end

        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = $signed({2'b00, big.exp}) + 10'sd1;
        end else begin
            // A shift of more than one only happens when d_exp <= 1, so no
            // sticky information is lost by shifting zeros in.
            norm  = sum[26:0] << lz;
            exp_n = $signed({2'b00, big.exp}) - $signed({5'b00000, lz});
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd      = {1'b0, norm[26:3]} + {24'b0, round_up};
        // Rounding carry-out leaves 1.000..0 with the exponent bumped.
        exp_r    = exp_n + (rnd[24] ? 10'sd1 : 10'sd0);
        mant     = rnd[23] ? rnd[22:0] : 23'b0;

        if (a_nan)
            y = a | FP_QUIET;
        else if (b_nan)
            y = b | FP_QUIET;
        else if (a_inf && b_inf && eff_sub)
            y = FP_QNAN;
        else if (a_inf)
            y = a;
        else if (b_inf)
            y = b;
        else if (a_zero && b_zero)
            y = {fa.sign & fb.sign, 31'b0};
        else if (a_zero)
            y = b;
        else if (b_zero)
            y = a;
        else if (sum == '0)
            y = FP_ZERO;
        else if (exp_r >= 10'sd255)
            y = {big.sign, 8'hFF, 23'b0};
        else if (exp_r <= 10'sd0)
            y = {big.sign, 31'b0};
        else
            y = {big.sign, exp_r[7:0], mant};
    end
endmodule

// File: rtl/pr_dst_accumulate.sv
// pr_dst_accumulate
//   Accumulates masked src_p contributions per destination vertex on four
//   independent lanes and writes a lane's sum out when its dst id changes
//   or on an end-of-pass flush.
//   Ports: clk, rst (sync, active-high); beat_if (slave: src_p beat and
//   dst lanes 1..4); flush_req (pulse) / flush_busy / flush_done (pulse);
//   overrun_err (sticky, beat seen while flushing); acc_wr_en[k-1],
//   acc_wr_addr, acc_wr_data (registered write per dst lane k).
//   Optional: define PR_ACC_STATS_EN to add beat_cnt / wr_cnt counters.
`ifndef EDGE_PIPE_NUM
`define EDGE_PIPE_NUM 4
`endif
`ifndef VERTEX_BRAM_DWIDTH
`define VERTEX_BRAM_DWIDTH 32
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH `EDGE_PIPE_NUM
`endif
`ifndef DST_ID_DWIDTH
`define DST_ID_DWIDTH 16
`endif

module pr_dst_accumulate
    import pr_dst_accumulate_pkg::*;
#(
    parameter int EDGE_PIPE_NUM      = `EDGE_PIPE_NUM,
    parameter int VERTEX_BRAM_DWIDTH = `VERTEX_BRAM_DWIDTH,
    parameter int MASK_WIDTH         = `MASK_WIDTH,
    parameter int DST_ID_DWIDTH      = `DST_ID_DWIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    pr_dst_accumulate_if.slave                      beat_if,
    input  logic                                    flush_req,
    output logic                                    flush_busy,
    output logic                                    flush_done,
    output logic                                    overrun_err,
`ifdef PR_ACC_STATS_EN
    output logic [31:0]                             beat_cnt,
    output logic [31:0]                             wr_cnt,
`endif
    output logic [DST_LANES-1:0]                    acc_wr_en,
    output logic [DST_LANES*DST_ID_DWIDTH-1:0]      acc_wr_addr,
    output logic [DST_LANES*VERTEX_BRAM_DWIDTH-1:0] acc_wr_data
);
    logic [DST_LANES-1:0][DST_ID_DWIDTH-1:0] dst_id;
    logic [DST_LANES-1:0][MASK_WIDTH-1:0]    dst_mask;
    logic [DST_LANES-1:0]                    dst_vld, accept;

    assign dst_id   = {beat_if.dst_id_4, beat_if.dst_id_3, beat_if.dst_id_2, beat_if.dst_id_1};
    assign dst_mask = {beat_if.src_p_mask_r_4, beat_if.src_p_mask_r_3,
                       beat_if.src_p_mask_r_2, beat_if.src_p_mask_r_1};
    assign dst_vld  = {beat_if.dst_data_valid_4, beat_if.dst_data_valid_3,
                       beat_if.dst_data_valid_2, beat_if.dst_data_valid_1};

    logic [1:0] state_q, state_d;
    logic       overrun_q, overrun_d;
    logic       in_run, flush_start, flush_now;

    assign in_run      = (state_q == ST_RUN);
    assign flush_start = in_run && flush_req;
    assign flush_now   = (state_q == ST_FLUSH);
    assign accept      = (beat_if.src_p_valid && in_run) ? dst_vld : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush_req) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        overrun_d = overrun_q | (flush_busy && beat_if.src_p_valid && (|dst_vld));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    assign flush_busy  = !in_run;
    assign flush_done  = (state_q == ST_DONE);
    assign overrun_err = overrun_q;

    for (genvar k = 0; k < DST_LANES; k++) begin : g_lane
        pr_dst_accumulate_lane #(
            .EDGE_PIPE_NUM      (EDGE_PIPE_NUM),
            .VERTEX_BRAM_DWIDTH (VERTEX_BRAM_DWIDTH),
            .MASK_WIDTH         (MASK_WIDTH),
            .DST_ID_DWIDTH      (DST_ID_DWIDTH)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .src_p       (beat_if.src_p),
            .mask        (dst_mask[k]),
            .dst_id      (dst_id[k]),
            .accept      (accept[k]),
            .flush_start (flush_start),
            .flush_now   (flush_now),
            .wr_en       (acc_wr_en[k]),
            .wr_addr     (acc_wr_addr[k*DST_ID_DWIDTH +: DST_ID_DWIDTH]),
            .wr_data     (acc_wr_data[k*VERTEX_BRAM_DWIDTH +: VERTEX_BRAM_DWIDTH])
        );
    end

`ifdef PR_ACC_STATS_EN
    logic [31:0] beat_cnt_q, beat_cnt_d, wr_cnt_q, wr_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q + 32'(popcnt4(accept));
        wr_cnt_d   = wr_cnt_q + 32'(popcnt4(acc_wr_en));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            wr_cnt_q   <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
    assign wr_cnt   = wr_cnt_q;
`endif
endmodule

// File: tb/tb_pr_dst_accumulate.sv
// tb_pr_dst_accumulate
//   Self-checking bench for pr_dst_accumulate. Each row drives one cycle of
//   stimulus and pushes the write/status outcome expected right after the
//   following clock edge; the outcome is popped and compared after that edge.
`ifndef EDGE_PIPE_NUM
`define EDGE_PIPE_NUM 4
`endif
`ifndef VERTEX_BRAM_DWIDTH
`define VERTEX_BRAM_DWIDTH 32
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH `EDGE_PIPE_NUM
`endif
`ifndef DST_ID_DWIDTH
`define DST_ID_DWIDTH 16
`endif

module tb_pr_dst_accumulate;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int IW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              flush_req, flush_busy, flush_done, overrun_err;
    logic [3:0]        acc_wr_en;
    logic [4*IW-1:0]   acc_wr_addr;
    logic [4*DW-1:0]   acc_wr_data;
`ifdef PR_ACC_STATS_EN
    logic [31:0]       beat_cnt, wr_cnt;
`endif

    pr_dst_accumulate_if #(.EDGE_PIPE_NUM(N), .VERTEX_BRAM_DWIDTH(DW),
                           .MASK_WIDTH(MW), .DST_ID_DWIDTH(IW)) bif ();

    pr_dst_accumulate #(.EDGE_PIPE_NUM(N), .VERTEX_BRAM_DWIDTH(DW),
                        .MASK_WIDTH(MW), .DST_ID_DWIDTH(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .beat_if     (bif),
        .flush_req   (flush_req),
        .flush_busy  (flush_busy),
        .flush_done  (flush_done),
        .overrun_err (overrun_err),
`ifdef PR_ACC_STATS_EN
        .beat_cnt    (beat_cnt),
        .wr_cnt      (wr_cnt),
`endif
        .acc_wr_en   (acc_wr_en),
        .acc_wr_addr (acc_wr_addr),
        .acc_wr_data (acc_wr_data)
    );

    typedef struct {
        logic                   rst, v, fl;
        logic [3:0]             dv;
        logic [3:0][IW-1:0]     id;
        logic [3:0][MW-1:0]     mask;
        logic [N-1:0][DW-1:0]   src;
        logic [3:0]             we;
        logic [3:0][IW-1:0]     addr;
        logic [3:0][DW-1:0]     data;
        logic                   busy, done, ovr;
    } row_t;

    row_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [N-1:0][DW-1:0] S_A = {32'h3E800000, 32'h3E800000, 32'h3E800000, 32'h3F000000};
    localparam logic [N-1:0][DW-1:0] S_Q = {4{32'h3E800000}};

    function automatic row_t idle();
        row_t r;
        r.rst = 0; r.v = 0; r.fl = 0; r.dv = '0; r.id = '0; r.mask = '0; r.src = '0;
        r.we = '0; r.addr = '0; r.data = '0; r.busy = 0; r.done = 0; r.ovr = 0;
        return r;
    endfunction

    function automatic row_t b1(input int lane, input logic [IW-1:0] id,
                                input logic [MW-1:0] m, input logic [N-1:0][DW-1:0] s);
        row_t r = idle();
        r.v = 1; r.dv[lane] = 1; r.id[lane] = id; r.mask[lane] = m; r.src = s;
        return r;
    endfunction

    function automatic row_t ev(input row_t ri, input int lane, input logic [IW-1:0] a,
                                input logic [DW-1:0] d);
        row_t r = ri;
        r.we[lane] = 1; r.addr[lane] = a; r.data[lane] = d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input row_t r);
        row_t e;
        @(negedge clk);
        rst = r.rst; flush_req = r.fl;
        bif.src_p = r.src; bif.src_p_valid = r.v;
        bif.dst_id_1 = r.id[0]; bif.dst_id_2 = r.id[1]; bif.dst_id_3 = r.id[2]; bif.dst_id_4 = r.id[3];
        bif.src_p_mask_r_1 = r.mask[0]; bif.src_p_mask_r_2 = r.mask[1];
        bif.src_p_mask_r_3 = r.mask[2]; bif.src_p_mask_r_4 = r.mask[3];
        bif.dst_data_valid_1 = r.dv[0]; bif.dst_data_valid_2 = r.dv[1];
        bif.dst_data_valid_3 = r.dv[2]; bif.dst_data_valid_4 = r.dv[3];
        exp_q.push_back(r);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("acc_wr_en", 128'(acc_wr_en), 128'(e.we));
        for (int k = 0; k < 4; k++) begin
            if (e.we[k]) begin
                chk($sformatf("wr_addr_%0d", k + 1), 128'(acc_wr_addr[k*IW +: IW]), 128'(e.addr[k]));
                chk($sformatf("wr_data_%0d", k + 1), 128'(acc_wr_data[k*DW +: DW]), 128'(e.data[k]));
            end
        end
        if (e.rst) begin
            chk("rst_wr_addr", 128'(acc_wr_addr), 128'(0));
            chk("rst_wr_data", acc_wr_data, 128'(0));
        end
        chk("flush_busy", 128'(flush_busy), 128'(e.busy));
        chk("flush_done", 128'(flush_done), 128'(e.done));
        chk("overrun_err", 128'(overrun_err), 128'(e.ovr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    row_t vec[12];
    row_t r;

    initial begin
        // Single-lane accumulate / evict and float corner cases.
        vec[0]  = b1(0, 5, 4'b0011, S_A);
        vec[1]  = b1(0, 5, 4'b0001, S_Q);
        vec[2]  = ev(b1(0, 9, 4'b0010, S_Q), 0, 5, 32'h3F800000);
        vec[3]  = ev(b1(0, 7, 4'b0000, S_Q), 0, 9, 32'h3E800000);
        vec[4]  = ev(b1(0, 8, 4'b0001, S_A), 0, 7, 32'h00000000);
        vec[5]  = b1(1, 20, 4'b0011, {32'h0, 32'h0, 32'h33800000, 32'h3F800000});
        vec[6]  = ev(b1(1, 21, 4'b0011, {32'h0, 32'h0, 32'h33800001, 32'h3F800000}), 1, 20, 32'h3F800000);
        vec[7]  = ev(b1(1, 22, 4'b0011, {32'h0, 32'h0, 32'hBF400000, 32'h3F800000}), 1, 21, 32'h3F800001);
        vec[8]  = ev(b1(1, 23, 4'b0101, {32'h0, 32'h3F800000, 32'h0, 32'h7F800000}), 1, 22, 32'h3E800000);
        vec[9]  = ev(b1(1, 24, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h00000001}), 1, 23, 32'h7F800000);
        vec[10] = b1(1, 24, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h40000000});
        vec[11] = ev(b1(1, 25, 4'b0000, S_Q), 1, 24, 32'h40000000);

        rst = 1; flush_req = 0; bif.src_p = '0; bif.src_p_valid = 0;
        bif.dst_id_1 = '0; bif.dst_id_2 = '0; bif.dst_id_3 = '0; bif.dst_id_4 = '0;
        bif.src_p_mask_r_1 = '0; bif.src_p_mask_r_2 = '0; bif.src_p_mask_r_3 = '0; bif.src_p_mask_r_4 = '0;
        bif.dst_data_valid_1 = 0; bif.dst_data_valid_2 = 0; bif.dst_data_valid_3 = 0; bif.dst_data_valid_4 = 0;

        r = idle(); r.rst = 1;
        step(r);
        step(r);

        for (int i = 0; i < 12; i++) step(vec[i]);

        // Reset with lanes 1 and 2 holding sums: no write, everything zero.
        r = b1(0, 99, 4'b0001, S_Q); r.rst = 1;
        step(r);
        step(b1(0, 100, 4'b0001, S_A));
        r = idle(); r.rst = 1;
        step(r);

        // Four lanes active, then flush.
        r = idle(); r.v = 1; r.dv = 4'hF;
        r.id = {16'd4, 16'd3, 16'd2, 16'd1};
        r.mask = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
        r.src = S_A;
        step(r);
        r = idle(); r.fl = 1; r.we = 4'hF; r.busy = 1;
        r.addr = {16'd4, 16'd3, 16'd2, 16'd1};
        r.data = {32'h3E800000, 32'h3E800000, 32'h3E800000, 32'h3F000000};
        step(r);
        r = idle(); r.busy = 1; r.done = 1;
        step(r);
        step(idle());
        step(b1(0, 50, 4'b0001, S_A));

        // Beats during flush are dropped and latch overrun_err; flush_req is ignored.
        r = ev(idle(), 0, 50, 32'h3F000000); r.fl = 1; r.busy = 1;
        step(r);
        r = b1(0, 60, 4'b0011, S_A); r.fl = 1; r.busy = 1; r.done = 1; r.ovr = 1;
        step(r);
        r = b1(0, 61, 4'b0001, S_A); r.ovr = 1;
        step(r);
        r = idle(); r.ovr = 1;
        step(r);
        r = b1(0, 70, 4'b0001, S_A); r.ovr = 1;
        step(r);
        r = ev(b1(0, 71, 4'b0010, S_Q), 0, 70, 32'h3F000000); r.ovr = 1;
        step(r);

        // Flush request together with an id change: eviction first, new sum next.
        r = ev(b1(0, 72, 4'b0001, S_A), 0, 71, 32'h3E800000); r.fl = 1; r.busy = 1; r.ovr = 1;
        step(r);
        r = ev(idle(), 0, 72, 32'h3F000000); r.busy = 1; r.done = 1; r.ovr = 1;
        step(r);
        r = idle(); r.ovr = 1;
        step(r);
        r = idle(); r.rst = 1;
        step(r);

        // Reset during FLUSH discards the deferred write.
        step(b1(0, 80, 4'b0001, S_A));
        r = ev(b1(0, 81, 4'b0010, S_Q), 0, 80, 32'h3F000000); r.fl = 1; r.busy = 1;
        step(r);
        r = idle(); r.rst = 1;
        step(r);
        step(idle());

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
